// File: rtl/count_frame_serializer.sv
// Snapshots a pulse-counter frame on each end-of-collection rising edge and shifts it out
// as back-to-back async serial words (start bit, LSB-first data, stop bit), idle-high line.
module count_frame_serializer #(
    parameter int NWORDS  = 53,
    parameter int WORD_W  = 10,
    parameter int BIT_DIV = 50
) (
    input  logic                     clk50,
    input  logic                     rst,
    input  logic [NWORDS*WORD_W-1:0] counts_flat,
    input  logic                     cnt_done,
    output logic                     cnt_clr,
    output logic                     ser_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               overrun_cnt
);

    localparam int FRAME_W = NWORDS * WORD_W;
    localparam int TIMER_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int WIDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int BIDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIT_DIV - 1);
    localparam logic [WIDX_W-1:0]  WIDX_LAST  = WIDX_W'(NWORDS - 1);
    localparam logic [BIDX_W-1:0]  BIDX_LAST  = BIDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 cnt_done_d_q, cnt_done_d_d;
    logic [FRAME_W-1:0]   snap_q, snap_d;
    logic [WORD_W-1:0]    shift_q, shift_d;
    logic [WIDX_W-1:0]    word_idx_q, word_idx_d;
    logic [BIDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 ser_data_q, ser_data_d;
    logic                 busy_q, busy_d;
    logic                 cnt_clr_q, cnt_clr_d;
    logic                 frame_done_q, frame_done_d;
    logic [7:0]           overrun_q, overrun_d;

    logic                 trigger;
    logic                 bit_end;
    logic [WORD_W-1:0]    cur_word;

    assign trigger = cnt_done & ~cnt_done_d_q;
    assign bit_end = (timer_q == TIMER_LAST);

    // Word currently addressed in the snapshot; loaded into the shifter when its start bit ends.
    always_comb begin
        cur_word = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (word_idx_q == WIDX_W'(k)) begin
                cur_word = snap_q[k*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_done_d_d = cnt_done;
        snap_d       = snap_q;
        shift_d      = shift_q;
        word_idx_d   = word_idx_q;
        bit_idx_d    = bit_idx_q;
        timer_d      = bit_end ? '0 : timer_q + 1'b1;
        ser_data_d   = ser_data_q;
        busy_d       = busy_q;
        cnt_clr_d    = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        // A strobe arriving while any bit (even the last stop cycle) is on the line is dropped.
        if (trigger && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (trigger) begin
                    snap_d     = counts_flat;
                    cnt_clr_d  = 1'b1;
                    busy_d     = 1'b1;
                    word_idx_d = '0;
                    bit_idx_d  = '0;
                    ser_data_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    ser_data_d = cur_word[0];
                    shift_d    = cur_word >> 1;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == BIDX_LAST) begin
                        ser_data_d = 1'b1;
                        state_d    = STOP;
                    end else begin
                        ser_data_d = shift_q[0];
                        shift_d    = shift_q >> 1;
                        bit_idx_d  = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (word_idx_q != WIDX_LAST) begin
                        word_idx_d = word_idx_q + 1'b1;
                        ser_data_d = 1'b0;
                        state_d    = START;
                    end else begin
                        ser_data_d   = 1'b1;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                ser_data_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_done_d_q <= 1'b0;
            word_idx_q   <= '0;
            bit_idx_q    <= '0;
            timer_q      <= '0;
            ser_data_q   <= 1'b1;
            busy_q       <= 1'b0;
            cnt_clr_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_done_d_q <= cnt_done_d_d;
            word_idx_q   <= word_idx_d;
            bit_idx_q    <= bit_idx_d;
            timer_q      <= timer_d;
            ser_data_q   <= ser_data_d;
            busy_q       <= busy_d;
            cnt_clr_q    <= cnt_clr_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Data path holds no meaningful reset value; it is always reloaded on a trigger.
    always_ff @(posedge clk50) begin
        snap_q  <= snap_d;
        shift_q <= shift_d;
    end

    assign cnt_clr     = cnt_clr_q;
    assign ser_data    = ser_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_count_frame_serializer.sv
// Randomized bench for count_frame_serializer (BIT_DIV=4): line waveform and UART-decoded
// words are compared with a frame model built from the word list.
module tb_count_frame_serializer;

    localparam int NW = 53;
    localparam int WW = 10;
    localparam int BD = 4;
    localparam int NBITS = NW * (WW + 2);
    localparam int FL = NBITS * BD;

    logic             clk50 = 1'b0;
    logic             rst = 1'b1;
    logic             cnt_done = 1'b0;
    logic [NW*WW-1:0] counts_flat = '0;
    logic             cnt_clr, ser_data, busy, frame_done;
    logic [7:0]       overrun_cnt;

    count_frame_serializer #(.NWORDS(NW), .WORD_W(WW), .BIT_DIV(BD)) dut (
        .clk50       (clk50),
        .rst         (rst),
        .counts_flat (counts_flat),
        .cnt_done    (cnt_done),
        .cnt_clr     (cnt_clr),
        .ser_data    (ser_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk50 = ~clk50;

    int vectors = 0;
    int miscompares = 0;
    int exp_overrun = 0;

    logic [WW-1:0] words [NW];
    logic          line_q [$];
    logic [WW-1:0] dec_q [$];
    int clr_cycles, clr_first_k, fd_count, fd_first_k, busy_low_k;

    function automatic void load_words();
        for (int k = 0; k < NW; k++) counts_flat[WW*k +: WW] = words[k];
    endfunction

    function automatic void random_words();
        for (int k = 0; k < NW; k++) words[k] = WW'($urandom);
        load_words();
    endfunction

    // Expected line level during cycle T+k, from the frame format alone.
    function automatic logic exp_bit(input int k, input int rst_k);
        int idx, w, p;
        if (rst_k > 0 && k > rst_k) return 1'b1;
        idx = (k - 1) / BD;
        if (idx >= NBITS) return 1'b1;
        w = idx / (WW + 2);
        p = idx % (WW + 2);
        if (p == 0) return 1'b0;
        if (p == WW + 1) return 1'b1;
        return words[w][p-1];
    endfunction

    function automatic int line_errors(input int max_k, input int rst_k);
        int n = 0;
        for (int k = 1; k <= max_k && k <= line_q.size(); k++)
            if (line_q[k-1] !== exp_bit(k, rst_k)) n++;
        return n;
    endfunction

    // Receiver model: find falling edges from idle, sample each bit at its centre.
    function automatic void decode_line();
        int i;
        logic [WW-1:0] w;
        dec_q.delete();
        i = 0;
        while (i + (WW + 1) * BD + BD / 2 < line_q.size()) begin
            if (line_q[i] == 1'b0 && (i == 0 || line_q[i-1] == 1'b1) && line_q[i+BD/2] == 1'b0) begin
                for (int j = 0; j < WW; j++) w[j] = line_q[i + (j + 1) * BD + BD / 2];
                if (line_q[i + (WW + 1) * BD + BD / 2] == 1'b1) begin
                    dec_q.push_back(w);
                    i = i + (WW + 2) * BD - 1;
                end
            end
            i++;
        end
    endfunction

    function automatic int decode_errors(input int n);
        int e = 0;
        for (int i = 0; i < n && i < dec_q.size(); i++)
            if (dec_q[i] !== words[i]) e++;
        return e;
    endfunction

    // Raise cnt_done, then observe ncyc cycles (k = cycles after the trigger edge).
    task automatic run_frame(input int ncyc, input int corrupt_k, input int rise_start,
                             input int n_rises, input bit hold, input int rst_k);
        line_q.delete();
        clr_cycles = 0; clr_first_k = -1; fd_count = 0; fd_first_k = -1; busy_low_k = -1;
        @(negedge clk50);
        cnt_done = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk50);
            line_q.push_back(ser_data);
            if (cnt_clr) begin
                clr_cycles++;
                if (clr_first_k < 0) clr_first_k = k;
            end
            if (frame_done) begin
                fd_count++;
                if (fd_first_k < 0) fd_first_k = k;
            end
            if (!busy && busy_low_k < 0) busy_low_k = k;
            if (!hold) begin
                cnt_done = 1'b0;
                if (n_rises > 0 && k >= rise_start && k < rise_start + 2 * n_rises)
                    cnt_done = ((k - rise_start) % 2 == 0);
            end
            if (k == corrupt_k) counts_flat = '1;
            rst = (k == rst_k);
        end
        cnt_done = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk50);
        decode_line();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk50);
        if (ser_data !== 1'b1) begin miscompares++; $display("FAIL reset_ser_data: got %b expected 1", ser_data); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (cnt_clr !== 1'b0) begin miscompares++; $display("FAIL reset_cnt_clr: got %b expected 0", cnt_clr); end
        vectors++;
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        vectors++;
        if (overrun_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt); end
        vectors++;
        rst = 1'b0;
        exp_overrun = 0;
        repeat (2) @(negedge clk50);
        $display("reset: ser_data=%b busy=%b overrun=%0d", ser_data, busy, overrun_cnt);
    endtask

    task automatic test_full_frame();
        logic first12 [12] = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        int e;
        words[0] = 10'h3BE; words[1] = 10'h2FB; words[NW-1] = 10'h2BF;
        for (int k = 2; k < NW - 1; k++) words[k] = WW'(k - 2);
        load_words();
        run_frame(FL + 16, 0, 0, 0, 1'b0, 0);
        if (clr_cycles !== 1 || clr_first_k !== 1) begin
            miscompares++; $display("FAIL full_cnt_clr: got %0d cycles at k=%0d expected 1 at k=1", clr_cycles, clr_first_k);
        end
        vectors++;
        if (line_q[0] !== 1'b0) begin miscompares++; $display("FAIL full_start_fall: got %b expected 0", line_q[0]); end
        vectors++;
        e = 0;
        for (int i = 0; i < 12 * BD; i++) if (line_q[i] !== first12[i / BD]) e++;
        if (e != 0) begin miscompares++; $display("FAIL full_first12: got %0d bad samples expected 0", e); end
        vectors++;
        e = line_errors(FL + 16, 0);
        if (e != 0) begin miscompares++; $display("FAIL full_line: got %0d bad samples expected 0", e); end
        vectors++;
        e = decode_errors(NW);
        if (dec_q.size() != NW || e != 0) begin
            miscompares++; $display("FAIL full_decode: got %0d words %0d wrong expected %0d words 0 wrong", dec_q.size(), e, NW);
        end
        vectors++;
        if (fd_first_k !== FL + 1 || fd_count !== 1) begin
            miscompares++; $display("FAIL full_frame_done: got k=%0d count=%0d expected k=%0d count=1", fd_first_k, fd_count, FL + 1);
        end
        vectors++;
        if (busy_low_k !== FL + 1) begin miscompares++; $display("FAIL full_busy_fall: got k=%0d expected k=%0d", busy_low_k, FL + 1); end
        vectors++;
        $display("full_frame: decoded %0d words, frame_done at k=%0d", dec_q.size(), fd_first_k);
    endtask

    task automatic test_snapshot();
        int e;
        random_words();
        run_frame(FL + 16, 1, 0, 0, 1'b0, 0);
        e = decode_errors(NW);
        if (dec_q.size() != NW || e != 0) begin
            miscompares++; $display("FAIL snapshot_decode: got %0d words %0d wrong expected %0d words 0 wrong", dec_q.size(), e, NW);
        end
        vectors++;
        e = line_errors(FL + 16, 0);
        if (e != 0) begin miscompares++; $display("FAIL snapshot_line: got %0d bad samples expected 0", e); end
        vectors++;
        $display("snapshot: decoded %0d words after counts_flat forced to ones", dec_q.size());
    endtask

    task automatic test_held();
        int e;
        rst = 1'b1;
        repeat (2) @(negedge clk50);
        rst = 1'b0;
        exp_overrun = 0;
        random_words();
        run_frame(6000, 0, 0, 0, 1'b1, 0);
        if (clr_cycles !== 1) begin miscompares++; $display("FAIL held_cnt_clr: got %0d expected 1", clr_cycles); end
        vectors++;
        if (fd_count !== 1) begin miscompares++; $display("FAIL held_frame_done: got %0d expected 1", fd_count); end
        vectors++;
        if (overrun_cnt !== 8'd0) begin miscompares++; $display("FAIL held_overrun: got %0d expected 0", overrun_cnt); end
        vectors++;
        e = decode_errors(NW);
        if (dec_q.size() != NW || e != 0) begin
            miscompares++; $display("FAIL held_decode: got %0d words %0d wrong expected %0d words 0 wrong", dec_q.size(), e, NW);
        end
        vectors++;
        $display("held: frames=%0d clears=%0d overrun=%0d", fd_count, clr_cycles, overrun_cnt);
    endtask

    task automatic test_overrun(input int rise_start, input int n);
        int e;
        random_words();
        run_frame(FL + 16, 0, rise_start, n, 1'b0, 0);
        exp_overrun = (exp_overrun + n > 255) ? 255 : exp_overrun + n;
        if (overrun_cnt !== 8'(exp_overrun)) begin
            miscompares++; $display("FAIL overrun_%0d_cnt: got %0d expected %0d", n, overrun_cnt, exp_overrun);
        end
        vectors++;
        e = line_errors(FL + 16, 0);
        if (e != 0) begin miscompares++; $display("FAIL overrun_%0d_line: got %0d bad samples expected 0", n, e); end
        vectors++;
        if (fd_count !== 1 || clr_cycles !== 1) begin
            miscompares++; $display("FAIL overrun_%0d_frames: got done=%0d clr=%0d expected 1 and 1", n, fd_count, clr_cycles);
        end
        vectors++;
        $display("overrun: %0d rises from k=%0d, overrun_cnt=%0d", n, rise_start, overrun_cnt);
    endtask

    task automatic test_back_to_back();
        int e;
        random_words();
        run_frame(FL + 16, 0, FL + 1, 1, 1'b0, 0);
        if (clr_cycles !== 2) begin miscompares++; $display("FAIL b2b_accept: got %0d clears expected 2", clr_cycles); end
        vectors++;
        if (overrun_cnt !== 8'(exp_overrun)) begin
            miscompares++; $display("FAIL b2b_overrun: got %0d expected %0d", overrun_cnt, exp_overrun);
        end
        vectors++;
        if (line_q[FL+1] !== 1'b0 || busy_low_k !== FL + 1) begin
            miscompares++; $display("FAIL b2b_restart: got ser=%b busy_low_k=%0d expected 0 and %0d", line_q[FL+1], busy_low_k, FL + 1);
        end
        vectors++;
        e = line_errors(FL + 1, 0);
        if (e != 0) begin miscompares++; $display("FAIL b2b_line: got %0d bad samples expected 0", e); end
        vectors++;
        repeat (FL + 8) @(negedge clk50);
        $display("back_to_back: second frame accepted at k=%0d", FL + 1);
    endtask

    task automatic test_mid_reset();
        int e;
        int rk = 1 + 20 * (WW + 2) * BD;
        random_words();
        run_frame(FL + 16, 0, 0, 0, 1'b0, rk);
        exp_overrun = 0;
        if (line_q[rk] !== 1'b1 || busy_low_k !== rk + 1) begin
            miscompares++; $display("FAIL midrst_idle: got ser=%b busy_low_k=%0d expected 1 and %0d", line_q[rk], busy_low_k, rk + 1);
        end
        vectors++;
        if (fd_count !== 0) begin miscompares++; $display("FAIL midrst_frame_done: got %0d expected 0", fd_count); end
        vectors++;
        if (overrun_cnt !== 8'(exp_overrun)) begin miscompares++; $display("FAIL midrst_overrun: got %0d expected 0", overrun_cnt); end
        vectors++;
        e = line_errors(FL + 16, rk);
        if (e != 0) begin miscompares++; $display("FAIL midrst_line: got %0d bad samples expected 0", e); end
        vectors++;
        e = decode_errors(20);
        if (dec_q.size() != 20 || e != 0) begin
            miscompares++; $display("FAIL midrst_partial: got %0d words %0d wrong expected 20 words 0 wrong", dec_q.size(), e);
        end
        vectors++;
        $display("mid_reset: reset at k=%0d, %0d words sent before abort", rk, dec_q.size());
        random_words();
        run_frame(FL + 16, 0, 0, 0, 1'b0, 0);
        e = decode_errors(NW);
        if (dec_q.size() != NW || e != 0 || fd_first_k !== FL + 1) begin
            miscompares++; $display("FAIL postrst_frame: got %0d words %0d wrong done k=%0d expected %0d words 0 wrong k=%0d",
                                   dec_q.size(), e, fd_first_k, NW, FL + 1);
        end
        vectors++;
        $display("post_reset: decoded %0d words, frame_done at k=%0d", dec_q.size(), fd_first_k);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_snapshot();
        test_held();
        test_overrun(100, 2);
        test_overrun(FL, 1);
        test_back_to_back();
        test_overrun(100, 300);
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
